// File: rtl/alloc_pkg.sv
// Shared helpers for slot pool trackers:
// index/count widths, slot index type and popcount.
package alloc_pkg;

    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int SLOT_IDXW = idx_width(8);
    typedef logic [SLOT_IDXW-1:0] slot_idx_t;

    localparam int POP_MAXW = 64;

    function automatic int unsigned popcount(
        input logic [POP_MAXW-1:0] v
    );
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAXW; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/psel_gen.sv
// Multi-lane priority selector: lane k gets a one-hot
// of the k-th lowest set bit of req (zero if none left).
module psel_gen #(
    parameter int REQS  = 4,
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]      req,
    output logic [REQS*WIDTH-1:0] gnt_bus
);

    // Peel off the lowest remaining request once per lane.
    always_comb begin
        logic [WIDTH-1:0] rem;
        logic [WIDTH-1:0] pick;
        rem     = req;
        pick    = '0;
        gnt_bus = '0;
        for (int k = 0; k < REQS; k++) begin
            pick = rem & ~(rem - WIDTH'(1));
            gnt_bus[k*WIDTH +: WIDTH] = pick;
            rem = rem & ~pick;
        end
    end

endmodule

// File: rtl/slot_alloc_tracker.sv
// Busy/free tracker for a pool of slots; hands out up to
// REQS lowest free indices per cycle, all-or-nothing.
module slot_alloc_tracker
    import alloc_pkg::*;
#(
    parameter int REQS  = 4,
    parameter int WIDTH = 8,
    parameter int IDXW  = idx_width(WIDTH),
    parameter int CNTW  = cnt_width(WIDTH)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [$clog2(REQS+1)-1:0] alloc_num,
    output logic                    alloc_ok,
    output logic [REQS-1:0]         alloc_vld,
    output logic [REQS*IDXW-1:0]    alloc_idx,
    input  logic [WIDTH-1:0]        release_mask,
    output logic [WIDTH-1:0]        busy,
    output logic [CNTW-1:0]         free_cnt,
    output logic                    full,
    output logic                    empty,
    output logic                    release_err
);

    logic [WIDTH-1:0]      busy_q, busy_d;
    logic [CNTW-1:0]       free_cnt_q, free_cnt_d;
    logic                  release_err_q, release_err_d;
    logic [REQS*WIDTH-1:0] gnt_bus;
    logic [WIDTH-1:0]      granted;
    logic [WIDTH-1:0]      eff_rel;

    psel_gen #(
        .REQS  (REQS),
        .WIDTH (WIDTH)
    ) u_psel (
        .req     (~busy_q),
        .gnt_bus (gnt_bus)
    );

    // Grant decision, lane valids, one-hot to index per lane.
    always_comb begin
        logic [WIDTH-1:0] lane;
        logic [IDXW-1:0]  idx;
        lane      = '0;
        idx       = '0;
        alloc_vld = '0;
        alloc_idx = '0;
        granted   = '0;
        alloc_ok  = reset_n && (alloc_num != '0)
                 && (int'(alloc_num) <= int'(free_cnt_q));
        for (int k = 0; k < REQS; k++) begin
            lane = gnt_bus[k*WIDTH +: WIDTH];
            idx  = '0;
            for (int b = 0; b < WIDTH; b++) begin
                if (lane[b]) idx = idx | IDXW'(b);
            end
            alloc_idx[k*IDXW +: IDXW] = idx;
            if (alloc_ok && (k < int'(alloc_num))) begin
                alloc_vld[k] = 1'b1;
                granted      = granted | lane;
            end
        end
    end

    // Next-state: releases only hit busy slots; stray ones flag an error.
    always_comb begin
        eff_rel       = release_mask & busy_q;
        busy_d        = (busy_q & ~eff_rel) | granted;
        free_cnt_d    = free_cnt_q
                      - CNTW'(popcount(POP_MAXW'(granted)))
                      + CNTW'(popcount(POP_MAXW'(eff_rel)));
        release_err_d = release_err_q
                      | (|(release_mask & ~busy_q));
    end

    // State registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q        <= '0;
            free_cnt_q    <= CNTW'(WIDTH);
            release_err_q <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            free_cnt_q    <= free_cnt_d;
            release_err_q <= release_err_d;
        end
    end

    assign busy        = busy_q;
    assign free_cnt    = free_cnt_q;
    assign release_err = release_err_q;
    assign full        = (free_cnt_q == '0);
    assign empty       = (free_cnt_q == CNTW'(WIDTH));

endmodule

// File: tb/tb_slot_alloc_tracker.sv
// Directed bench for slot_alloc_tracker (REQS=4, WIDTH=8).
// Each scenario task checks its own expected values.
module tb_slot_alloc_tracker;

    localparam int REQS  = 4;
    localparam int WIDTH = 8;
    localparam int IDXW  = 3;
    localparam int CNTW  = 4;

    logic             clock;
    logic             reset_n;
    logic [2:0]       alloc_num;
    logic             alloc_ok;
    logic [REQS-1:0]  alloc_vld;
    logic [REQS*IDXW-1:0] alloc_idx;
    logic [WIDTH-1:0] release_mask;
    logic [WIDTH-1:0] busy;
    logic [CNTW-1:0]  free_cnt;
    logic             full;
    logic             empty;
    logic             release_err;

    int passed;
    int total;

    slot_alloc_tracker #(
        .REQS  (REQS),
        .WIDTH (WIDTH)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .alloc_num    (alloc_num),
        .alloc_ok     (alloc_ok),
        .alloc_vld    (alloc_vld),
        .alloc_idx    (alloc_idx),
        .release_mask (release_mask),
        .busy         (busy),
        .free_cnt     (free_cnt),
        .full         (full),
        .empty        (empty),
        .release_err  (release_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [IDXW-1:0] lane_idx(input int k);
        return alloc_idx[k*IDXW +: IDXW];
    endfunction

    // free_cnt must always match the busy vector.
    always @(negedge clock) begin
        if (reset_n) begin
            total++;
            if (free_cnt !== CNTW'(WIDTH - $countones(busy)))
                $display("FAIL consistency: free_cnt=%0d busy=%h",
                         free_cnt, busy);
            else
                passed++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_state(input string nm,
                             input logic [7:0] exp_busy,
                             input int exp_cnt,
                             input logic exp_full,
                             input logic exp_empty,
                             input logic exp_err);
        total++;
        if (busy !== exp_busy || free_cnt !== CNTW'(exp_cnt)
            || full !== exp_full || empty !== exp_empty
            || release_err !== exp_err)
            $display("FAIL %s: busy=%h cnt=%0d full=%b empty=%b err=%b want %h %0d %b %b %b",
                     nm, busy, free_cnt, full, empty, release_err,
                     exp_busy, exp_cnt, exp_full, exp_empty, exp_err);
        else
            passed++;
    endtask

    task automatic chk_alloc(input string nm,
                             input logic exp_ok,
                             input logic [3:0] exp_vld,
                             input int i0, input int i1,
                             input int i2, input int i3);
        int exp_i [4];
        logic bad;
        exp_i = '{i0, i1, i2, i3};
        bad = (alloc_ok !== exp_ok) || (alloc_vld !== exp_vld);
        for (int k = 0; k < REQS; k++) begin
            if (exp_vld[k] && lane_idx(k) !== IDXW'(exp_i[k]))
                bad = 1'b1;
        end
        total++;
        if (bad)
            $display("FAIL %s: ok=%b vld=%b idx=%h want ok=%b vld=%b idx=%0d,%0d,%0d,%0d",
                     nm, alloc_ok, alloc_vld, alloc_idx, exp_ok, exp_vld,
                     i0, i1, i2, i3);
        else
            passed++;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        alloc_num    = 3'd4;
        release_mask = '0;
        #2;
        chk_alloc("reset_alloc_gated", 1'b0, 4'b0000, 0, 0, 0, 0);
        tick();
        chk_state("reset_state", 8'h00, 8, 1'b0, 1'b1, 1'b0);
        alloc_num = 3'd0;
        @(negedge clock);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_alloc_four();
        alloc_num = 3'd4;
        #1;
        chk_alloc("alloc4_first", 1'b1, 4'b1111, 0, 1, 2, 3);
        tick();
        alloc_num = 3'd0;
        chk_state("alloc4_state", 8'h0F, 4, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_fill();
        alloc_num = 3'd4;
        #1;
        chk_alloc("fill_upper", 1'b1, 4'b1111, 4, 5, 6, 7);
        tick();
        alloc_num = 3'd1;
        chk_state("fill_full", 8'hFF, 0, 1'b1, 1'b0, 1'b0);
        #1;
        chk_alloc("full_reject", 1'b0, 4'b0000, 0, 0, 0, 0);
        tick();
        alloc_num = 3'd0;
        chk_state("full_hold", 8'hFF, 0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_partial();
        release_mask = 8'h07;
        tick();
        release_mask = '0;
        chk_state("partial_rel", 8'hF8, 3, 1'b0, 1'b0, 1'b0);
        alloc_num = 3'd4;
        #1;
        chk_alloc("over_request", 1'b0, 4'b0000, 0, 0, 0, 0);
        tick();
        chk_state("over_hold", 8'hF8, 3, 1'b0, 1'b0, 1'b0);
        alloc_num = 3'd3;
        #1;
        chk_alloc("exact_request", 1'b1, 4'b0111, 0, 1, 2, 0);
        tick();
        alloc_num = 3'd0;
        chk_state("exact_state", 8'hFF, 0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_release_no_bypass();
        release_mask = 8'h22;
        alloc_num    = 3'd1;
        #1;
        chk_alloc("no_bypass", 1'b0, 4'b0000, 0, 0, 0, 0);
        tick();
        release_mask = '0;
        alloc_num    = 3'd2;
        chk_state("after_rel22", 8'hDD, 2, 1'b0, 1'b0, 1'b0);
        #1;
        chk_alloc("realloc_1_5", 1'b1, 4'b0011, 1, 5, 0, 0);
        tick();
        alloc_num = 3'd0;
        chk_state("refilled", 8'hFF, 0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_release_err();
        release_mask = 8'hFE;
        tick();
        chk_state("busy_01", 8'h01, 7, 1'b0, 1'b0, 1'b0);
        release_mask = 8'h03;
        tick();
        release_mask = '0;
        chk_state("stray_release", 8'h00, 8, 1'b0, 1'b1, 1'b1);
        tick();
        chk_state("err_sticky", 8'h00, 8, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_burst();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        tick();
        chk_state("rst_clears_err", 8'h00, 8, 1'b0, 1'b1, 1'b0);
        alloc_num = 3'd4;
        tick();
        alloc_num = 3'd2;
        tick();
        alloc_num    = 3'd0;
        release_mask = 8'h03;
        tick();
        release_mask = '0;
        chk_state("busy_3c", 8'h3C, 4, 1'b0, 1'b0, 1'b0);
        alloc_num = 3'd2;
        #1;
        chk_alloc("pre_reset_grant", 1'b1, 4'b0011, 0, 1, 0, 0);
        reset_n = 1'b0;
        #1;
        chk_alloc("mid_reset_gated", 1'b0, 4'b0000, 0, 0, 0, 0);
        chk_state("mid_reset_state", 8'h00, 8, 1'b0, 1'b1, 1'b0);
        tick();
        chk_state("reset_no_commit", 8'h00, 8, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk_alloc("post_reset_alloc", 1'b1, 4'b0011, 0, 1, 0, 0);
        tick();
        alloc_num = 3'd0;
        chk_state("post_reset_state", 8'h03, 6, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_alloc_four();
        test_fill();
        test_partial();
        test_release_no_bypass();
        test_release_err();
        test_reset_mid_burst();
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
